// File: rtl/fp_posit_pkg.sv
// Shared widths, derived sizes and decoded-operand records for the FP x posit lane array.
package fp_posit_pkg;

  localparam int FP_EXP_W     = 5;
  localparam int FP_MAN_W     = 10;
  localparam int FP_ACT_W     = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_BIAS      = (1 << (FP_EXP_W - 1)) - 1;
  localparam int POS_MAX_PREC = 8;
  localparam int FRAC_MAX     = POS_MAX_PREC - 3;
  localparam int MO           = FP_MAN_W + FRAC_MAX + 2;
  localparam int SCALE_W      = 8;

  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic                      nar;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_MAX-1:0]       frac;
  } posit_dec_t;

  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic                      nar;
    logic signed [SCALE_W-1:0] exp;
    logic [FP_MAN_W:0]         sig;
  } act_dec_t;

  // Out-of-range word lengths fall back to the widest supported posit.
  function automatic logic [3:0] clamp_prec(input logic [3:0] p);
    if ((p < 4'd3) || (p > 4'(POS_MAX_PREC))) begin
      return 4'(POS_MAX_PREC);
    end else begin
      return p;
    end
  endfunction

  function automatic logic [1:0] clamp_es(input logic [1:0] e);
    if (e == 2'd3) begin
      return 2'd2;
    end else begin
      return e;
    end
  endfunction

endpackage

// File: rtl/fp_posit_mul_vec_posit_decode.sv
// Combinational decode of one posit word (value held in the low `precision` bits).
module posit_decode
  import fp_posit_pkg::*;
(
  input  logic [POS_MAX_PREC-1:0] word,
  input  logic [3:0]              precision,
  input  logic [1:0]              es,
  output posit_dec_t              dec
);

  logic [POS_MAX_PREC-1:0] al_s;
  logic [POS_MAX_PREC-2:0] body_s;
  logic [POS_MAX_PREC-2:0] rem_s;
  logic [3:0]              nb_s;
  logic [2:0]              run_s;
  logic [2:0]              used_s;
  logic                    rb_s;
  logic                    term_s;
  logic                    scan_done_s;
  logic signed [7:0]       k_s;
  logic [1:0]              e_s;

  // Left-align the word, fold negatives to magnitude, then split regime/exponent/fraction
  always_comb begin
    dec         = '0;
    al_s        = word << (4'(POS_MAX_PREC) - precision);
    nb_s        = precision - 4'd1;
    dec.zero    = (al_s == 8'h00);
    dec.nar     = (al_s == 8'h80);
    dec.sign    = al_s[POS_MAX_PREC-1];
    if (al_s[POS_MAX_PREC-1]) begin
      body_s = ~al_s[POS_MAX_PREC-2:0] + 7'd1;
    end else begin
      body_s = al_s[POS_MAX_PREC-2:0];
    end
    rb_s        = body_s[POS_MAX_PREC-2];
    run_s       = 3'd0;
    term_s      = 1'b0;
    scan_done_s = 1'b0;
    for (int i = 0; i < POS_MAX_PREC - 1; i++) begin
      if (!scan_done_s && (4'(i) < nb_s)) begin
        if (body_s[POS_MAX_PREC-2-i] == rb_s) begin
          run_s = run_s + 3'd1;
        end else begin
          term_s      = 1'b1;
          scan_done_s = 1'b1;
        end
      end else begin
        scan_done_s = 1'b1;
      end
    end
    used_s = run_s + {2'b00, term_s};
    rem_s  = body_s << used_s;
    if (rb_s) begin
      k_s = $signed({5'b00000, run_s}) - 8'sd1;
    end else begin
      k_s = 8'sd0 - $signed({5'b00000, run_s});
    end
    // Bits past the end of the word shifted in as zeros, so short exponents pad naturally.
    case (es)
      2'd0: begin
        e_s      = 2'd0;
        dec.frac = rem_s[6:2];
      end
      2'd1: begin
        e_s      = {1'b0, rem_s[6]};
        dec.frac = rem_s[5:1];
      end
      default: begin
        e_s      = rem_s[6:5];
        dec.frac = rem_s[4:0];
      end
    endcase
    dec.scale = (k_s <<< es) + $signed({6'b000000, e_s});
  end

endmodule

// File: rtl/fp_posit_mul_vec.sv
// Multi-lane FP x posit multiplier: bit-serial posit collection, decode, unnormalised multiply.
module fp_posit_mul_vec
  import fp_posit_pkg::*;
#(
  parameter int ACT_WIDTH  = FP_ACT_W,
  parameter int EXP_WIDTH  = FP_EXP_W,
  parameter int MAN_WIDTH  = FP_MAN_W,
  parameter int LANES      = 4,
  parameter int MAX_PREC   = POS_MAX_PREC,
  parameter int EXPO_WIDTH = SCALE_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ACT_WIDTH-1:0]                     act,
  input  logic [LANES-1:0]                         w,
  input  logic                                     valid,
  input  logic                                     set,
  input  logic [3:0]                               precision,
  input  logic [1:0]                               es,
  output logic [LANES-1:0]                         sign_out,
  output logic [LANES*EXPO_WIDTH-1:0]              exp_out,
  output logic [LANES*(MAN_WIDTH+MAX_PREC-1)-1:0]  mantissa_out,
  output logic                                     done,
  output logic [LANES-1:0]                         zero_out,
  output logic [LANES-1:0]                         NaR_out
);

  localparam int MO_L = MAN_WIDTH + MAX_PREC - 1;

  logic [3:0]           prec_r;
  logic [1:0]           es_r;
  logic [3:0]           cnt_r;
  logic [MAX_PREC-1:0]  sh_r [LANES];
  logic [ACT_WIDTH-1:0] act_cap_r;
  logic                 v1_r;
  logic [MAX_PREC-1:0]  word1_r [LANES];
  logic [ACT_WIDTH-1:0] act1_r;
  logic [3:0]           prec1_r;
  logic [1:0]           es1_r;
  posit_dec_t           pdec_s [LANES];
  act_dec_t             adec_s;
  logic                 v2_r;
  posit_dec_t           pdec2_r [LANES];
  act_dec_t             adec2_r;
  logic [EXP_WIDTH-1:0] aexp_s;
  logic [MAN_WIDTH-1:0] aman_s;
  logic [MO_L-1:0]      prod_s [LANES];
  logic signed [SCALE_W-1:0] sum_s [LANES];

  // Collect stage: configuration, bit-serial shifting and hand-off of completed words
  always_ff @(posedge clk) begin
    if (rst) begin
      prec_r    <= 4'(MAX_PREC);
      es_r      <= 2'd0;
      cnt_r     <= 4'd0;
      act_cap_r <= '0;
      v1_r      <= 1'b0;
      act1_r    <= '0;
      prec1_r   <= 4'(MAX_PREC);
      es1_r     <= 2'd0;
      for (int i = 0; i < LANES; i++) begin
        sh_r[i]    <= '0;
        word1_r[i] <= '0;
      end
    end else if (set) begin
      prec_r <= clamp_prec(precision);
      es_r   <= clamp_es(es);
      cnt_r  <= 4'd0;
      v1_r   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        sh_r[i] <= '0;
      end
    end else if (valid) begin
      for (int i = 0; i < LANES; i++) begin
        sh_r[i] <= {sh_r[i][MAX_PREC-2:0], w[i]};
      end
      if (cnt_r == 4'd0) begin
        act_cap_r <= act;
      end
      if (cnt_r == (prec_r - 4'd1)) begin
        cnt_r   <= 4'd0;
        v1_r    <= 1'b1;
        act1_r  <= act_cap_r;
        prec1_r <= prec_r;
        es1_r   <= es_r;
        for (int i = 0; i < LANES; i++) begin
          word1_r[i] <= {sh_r[i][MAX_PREC-2:0], w[i]};
        end
      end else begin
        cnt_r <= cnt_r + 4'd1;
        v1_r  <= 1'b0;
      end
    end else begin
      v1_r <= 1'b0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    posit_decode u_dec (
      .word      (word1_r[g]),
      .precision (prec1_r),
      .es        (es1_r),
      .dec       (pdec_s[g])
    );
  end

  assign aexp_s = act1_r[ACT_WIDTH-2 -: EXP_WIDTH];
  assign aman_s = act1_r[MAN_WIDTH-1:0];

  // Activation decode: subnormals use exponent 1-bias with a zero hidden bit
  always_comb begin
    adec_s      = '0;
    adec_s.sign = act1_r[ACT_WIDTH-1];
    adec_s.nar  = &aexp_s;
    adec_s.zero = (aexp_s == {EXP_WIDTH{1'b0}}) && (aman_s == {MAN_WIDTH{1'b0}});
    if (aexp_s == {EXP_WIDTH{1'b0}}) begin
      adec_s.exp = SCALE_W'(1 - FP_BIAS);
      adec_s.sig = {1'b0, aman_s};
    end else begin
      adec_s.exp = SCALE_W'(aexp_s) - SCALE_W'(FP_BIAS);
      adec_s.sig = {1'b1, aman_s};
    end
  end

  // Decode stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r    <= 1'b0;
      adec2_r <= '0;
      for (int i = 0; i < LANES; i++) begin
        pdec2_r[i] <= '0;
      end
    end else begin
      v2_r    <= v1_r;
      adec2_r <= adec_s;
      for (int i = 0; i < LANES; i++) begin
        pdec2_r[i] <= pdec_s[i];
      end
    end
  end

  // Per-lane significand product and exponent sum
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_s[i] = MO_L'(adec2_r.sig) * MO_L'({1'b1, pdec2_r[i].frac});
      sum_s[i]  = adec2_r.exp + pdec2_r[i].scale;
    end
  end

  // Multiply stage register: outputs update only on done and hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      done         <= 1'b0;
      sign_out     <= '0;
      exp_out      <= '0;
      mantissa_out <= '0;
      zero_out     <= '0;
      NaR_out      <= '0;
    end else begin
      done <= v2_r;
      if (v2_r) begin
        for (int i = 0; i < LANES; i++) begin
          sign_out[i]                            <= adec2_r.sign ^ pdec2_r[i].sign;
          NaR_out[i]                             <= adec2_r.nar | pdec2_r[i].nar;
          zero_out[i]                            <= !(adec2_r.nar | pdec2_r[i].nar) &&
                                                    (adec2_r.zero | pdec2_r[i].zero);
          exp_out[i*EXPO_WIDTH +: EXPO_WIDTH]    <= EXPO_WIDTH'(sum_s[i]);
          mantissa_out[i*MO_L +: MO_L]           <= prod_s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_posit_mul_vec.sv
// Randomised and directed bench for fp_posit_mul_vec against a numeric posit/FP16 model.
module tb_fp_posit_mul_vec;

  logic        clk;
  logic        rst;
  logic [15:0] act;
  logic [3:0]  w;
  logic        valid;
  logic        set;
  logic [3:0]  precision;
  logic [1:0]  es;
  logic [3:0]  sign_out;
  logic [31:0] exp_out;
  logic [67:0] mantissa_out;
  logic        done;
  logic [3:0]  zero_out;
  logic [3:0]  NaR_out;

  fp_posit_mul_vec dut (
    .clk(clk), .rst(rst), .act(act), .w(w), .valid(valid), .set(set),
    .precision(precision), .es(es), .sign_out(sign_out), .exp_out(exp_out),
    .mantissa_out(mantissa_out), .done(done), .zero_out(zero_out), .NaR_out(NaR_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int m_prec = 8;
  int m_es = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  s;
    logic [3:0]  z;
    logic [3:0]  nr;
    logic [31:0] ex;
    logic [67:0] mt;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [67:0] got, input logic [67:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Numeric reading of the posit and FP16 operands, walking bits by position.
  function automatic void model_lane(input int pin, input int n, input int ees, input logic [15:0] a,
                                     output logic s, output logic z, output logic nr,
                                     output logic [7:0] ex, output logic [16:0] mt);
    int p, idx, r, rb, k, e, fb, frac, aexp, asig;
    logic pz, pn, ps, anar, azero;
    p     = pin & ((1 << n) - 1);
    anar  = (a[14:10] == 5'h1F);
    azero = (a[14:0] == 15'h0000);
    aexp  = (a[14:10] == 5'h00) ? -14 : int'(a[14:10]) - 15;
    asig  = ((a[14:10] == 5'h00) ? 0 : 1024) + int'(a[9:0]);
    pz    = (p == 0);
    pn    = (p == (1 << (n - 1)));
    ps    = 1'b0;
    if (p >= (1 << (n - 1))) begin
      ps = 1'b1;
      p  = (1 << n) - p;
    end
    idx = n - 2;
    rb  = (p >> idx) & 1;
    r   = 0;
    while (idx >= 0 && ((p >> idx) & 1) == rb) begin
      r++;
      idx--;
    end
    if (idx >= 0) idx--;
    k = (rb == 1) ? r - 1 : -r;
    e = 0;
    for (int j = 0; j < ees; j++) begin
      e = e * 2 + ((idx >= 0) ? ((p >> idx) & 1) : 0);
      idx--;
    end
    fb   = (idx >= 0) ? idx + 1 : 0;
    frac = (p & ((1 << fb) - 1)) << (5 - fb);
    s    = a[15] ^ ps;
    nr   = anar | pn;
    z    = !nr && (azero || pz);
    ex   = 8'(aexp + k * (1 << ees) + e);
    mt   = 17'(asig * (32 + frac));
  endfunction

  // Compare every done pulse against the oldest outstanding word.
  always @(negedge clk) begin
    exp_t ee;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 68'd1, 68'd0);
      end else begin
        ee = q.pop_front();
        chk("done_cycle", 68'(cyc), 68'(ee.cyc));
        for (int l = 0; l < 4; l++) begin
          chk($sformatf("lane%0d_zero", l), 68'(zero_out[l]), 68'(ee.z[l]));
          chk($sformatf("lane%0d_nar", l), 68'(NaR_out[l]), 68'(ee.nr[l]));
          if (!ee.z[l] && !ee.nr[l]) begin
            chk($sformatf("lane%0d_sign", l), 68'(sign_out[l]), 68'(ee.s[l]));
            chk($sformatf("lane%0d_exp", l), 68'(exp_out[l*8 +: 8]), 68'(ee.ex[l*8 +: 8]));
            chk($sformatf("lane%0d_mant", l), 68'(mantissa_out[l*17 +: 17]), 68'(ee.mt[l*17 +: 17]));
          end
        end
      end
    end
  end

  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      set = 1'b0; valid = 1'b0; w = 4'($urandom); act = 16'($urandom);
    end
  endtask

  task automatic do_set(input int p, input int e);
    @(negedge clk);
    set = 1'b1; precision = 4'(p); es = 2'(e);
    valid = 1'($urandom); w = 4'($urandom);
    m_prec = (p < 3 || p > 8) ? 8 : p;
    m_es   = (e == 3) ? 2 : e;
  endtask

  task automatic partial(input logic [31:0] words, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk);
      set = 1'b0; valid = 1'b1; act = 16'($urandom);
      for (int i = 0; i < 4; i++) w[i] = words[i*8 + b];
    end
  endtask

  task automatic send_word(input logic [31:0] words, input logic [15:0] a,
                           input int stall_at, input int stall_len);
    exp_t en;
    logic s, z, nr;
    logic [7:0] ex;
    logic [16:0] mt;
    int n;
    n = m_prec;
    for (int i = 0; i < 4; i++) begin
      model_lane(int'(words[i*8 +: 8]), n, m_es, a, s, z, nr, ex, mt);
      en.s[i] = s; en.z[i] = z; en.nr[i] = nr;
      en.ex[i*8 +: 8] = ex; en.mt[i*17 +: 17] = mt;
    end
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      set = 1'b0; valid = 1'b1;
      act = (b == 0) ? a : 16'($urandom);
      for (int i = 0; i < 4; i++) w[i] = words[i*8 + n - 1 - b];
      if (b == n - 1) begin
        en.cyc = cyc + 3;
        q.push_back(en);
      end
      if (b == stall_at) begin
        repeat (stall_len) begin
          @(negedge clk);
          valid = 1'b0; w = 4'($urandom); act = 16'($urandom);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"}, 68'(done), 68'd0);
    chk({tag, "_sign"}, 68'(sign_out), 68'd0);
    chk({tag, "_exp"}, 68'(exp_out), 68'd0);
    chk({tag, "_mant"}, 68'(mantissa_out), 68'd0);
    chk({tag, "_zero"}, 68'(zero_out), 68'd0);
    chk({tag, "_nar"}, 68'(NaR_out), 68'd0);
  endtask

  initial begin
    logic s, z, nr;
    logic [7:0] ex;
    logic [16:0] mt;
    logic [31:0] wd;
    logic [15:0] a;
    int n;

    rst = 1'b1; act = 16'h0000; w = 4'h0; valid = 1'b0; set = 1'b0;
    precision = 4'd0; es = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Hand-computed values pin the model itself.
    model_lane(32'h4, 4, 0, 16'h3C00, s, z, nr, ex, mt);
    chk("model_one_exp", 68'(ex), 68'h00);
    chk("model_one_mant", 68'(mt), 68'h08000);
    model_lane(32'h60, 8, 1, 16'hC000, s, z, nr, ex, mt);
    chk("model_m8_sign", 68'(s), 68'd1);
    chk("model_m8_exp", 68'(ex), 68'h03);
    model_lane(32'h58, 8, 0, 16'h3E00, s, z, nr, ex, mt);
    chk("model_2p625_mant", 68'(mt), 68'h15000);
    model_lane(32'hC, 4, 0, 16'h3C00, s, z, nr, ex, mt);
    chk("model_neg_sign", 68'(s), 68'd1);
    model_lane(32'h8, 4, 0, 16'h0000, s, z, nr, ex, mt);
    chk("model_nar_over_zero", 68'({nr, z}), 68'b10);
    model_lane(32'h4, 4, 0, 16'h0001, s, z, nr, ex, mt);
    chk("model_subnormal", 68'({ex, mt}), 68'({8'hF2, 17'h00020}));

    // Directed words from the test plan.
    do_set(4, 0);
    send_word({4{8'h04}}, 16'h3C00, -1, 0);
    idle(4);
    do_set(8, 1);
    send_word({24'($urandom), 8'h60}, 16'hC000, -1, 0);
    do_set(8, 0);
    send_word({16'($urandom), 8'h58, 8'($urandom)}, 16'h3E00, -1, 0);
    do_set(4, 0);
    send_word({8'h04, 8'h0C, 8'h04, 8'h04}, 16'h3C00, -1, 0);
    send_word({8'h04, 8'h08, 8'h00, 8'h04}, 16'h3C00, -1, 0);
    send_word({4{8'h04}}, 16'h7C00, -1, 0);
    send_word({8'h04, 8'h00, 8'h08, 8'h08}, 16'h0000, -1, 0);
    idle(3);
    send_word({4{8'h04}}, 16'h3C00, 1, 3);
    send_word({8'h0F, 8'h01, 8'h07, 8'h0B}, 16'h4100, -1, 0);
    send_word({8'h03, 8'h0E, 8'h05, 8'h09}, 16'hB800, -1, 0);
    send_word({8'h06, 8'h02, 8'h0D, 8'h0A}, 16'h0155, -1, 0);
    idle(4);

    // Abort via set after two bits, then use the new configuration.
    partial(32'hFFFF_FFFF, 2);
    do_set(8, 2);
    send_word(32'h5A3C_E781, 16'h3555, -1, 0);
    idle(5);

    // Reset drops an in-flight word and a partial word, restores precision 8 / es 0.
    do_set(5, 1);
    send_word(32'h1234_5678, 16'h3C00, -1, 0);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; set = 1'b0;
    @(negedge clk);
    q.delete();
    check_reset_outputs("midrst");
    rst = 1'b0;
    partial(32'hA5A5_A5A5, 3);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("partrst");
    rst = 1'b0;
    m_prec = 8; m_es = 0;
    idle(4);
    send_word(32'h4060_7F21, 16'h3C00, -1, 0);
    idle(2);

    // Randomised traffic including special operands, stalls and reconfiguration.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 5) == 0) do_set(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      n  = m_prec;
      wd = $urandom;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 7))
          0: wd[i*8 +: 8] = 8'h00;
          1: wd[i*8 +: 8] = 8'((1 << (n - 1)) | ($urandom & 32'h0000_0100));
          default: wd[i*8 +: 8] = wd[i*8 +: 8];
        endcase
      end
      case ($urandom_range(0, 5))
        0: a = {1'($urandom), 15'h0000};
        1: a = {1'($urandom), 5'h1F, 10'($urandom)};
        2: a = {1'($urandom), 5'h00, 10'($urandom)};
        default: a = 16'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0)
        send_word(wd, a, int'($urandom_range(0, n - 2)), int'($urandom_range(1, 3)));
      else
        send_word(wd, a, -1, 0);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(6);
    chk("queue_drained", 68'(q.size()), 68'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
